// File: rtl/regfile.sv
// 32 x WIDTH register file for the ID stage.
// It has one clocked write port driven by a one-hot write-enable decoder and two
// combinational read ports, each built from a 32-to-1 mux.
// The ZERO_REG index always reads zero, and writes to it are discarded.
// When BYPASS is set, a read of the register being written in the same cycle
// returns WriteData, so the WB->ID hazard needs no separate forward.

module regfile_mux32to1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_data [32],
    input  logic [4:0]       i_sel,
    output logic [WIDTH-1:0] o_data
);

    // Plain 32-way selection; the register array is always fully populated.
    always_comb begin
        o_data = i_data[i_sel];
    end

endmodule

module regfile #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [31:0]      w_en;
    logic [WIDTH-1:0] w_regs [32];
    logic [WIDTH-1:0] w_mux1;
    logic [WIDTH-1:0] w_mux2;
    logic             w_hit1;
    logic             w_hit2;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                // The zero register has no storage, so its decode output is tied low.
                assign w_en[gi]   = 1'b0;
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] r_q;

                assign w_en[gi] = RegWrite && (WriteRegister == 5'(gi));

                // Reset wins over a coincident write; otherwise load only when selected.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_q <= '0;
                    end else if (w_en[gi]) begin
                        r_q <= WriteData;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    regfile_mux32to1 #(.WIDTH(WIDTH)) u_mux1 (
        .i_data (w_regs),
        .i_sel  (ReadRegister1),
        .o_data (w_mux1)
    );

    regfile_mux32to1 #(.WIDTH(WIDTH)) u_mux2 (
        .i_data (w_regs),
        .i_sel  (ReadRegister2),
        .o_data (w_mux2)
    );

    // A write-through hit needs a live write that reset is not about to suppress.
    assign w_hit1 = BYPASS && RegWrite && !reset && (WriteRegister == ReadRegister1);
    assign w_hit2 = BYPASS && RegWrite && !reset && (WriteRegister == ReadRegister2);

    // Port 1 output: the zero index wins over the bypass, and the bypass wins over storage.
    always_comb begin
        ReadData1 = w_mux1;
        if (ReadRegister1 == 5'(ZERO_REG)) begin
            ReadData1 = '0;
        end else if (w_hit1) begin
            ReadData1 = WriteData;
        end
    end

    // Port 2 output: the same priority as port 1.
    always_comb begin
        ReadData2 = w_mux2;
        if (ReadRegister2 == 5'(ZERO_REG)) begin
            ReadData2 = '0;
        end else if (w_hit2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile.
// Two instances share one set of inputs: one has write-through enabled and one
// has it disabled. The stimulus process predicts the read data from a simple
// array model and queues the prediction. A monitor samples both instances on the
// falling edge and compares their outputs against the queue.

module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    regfile #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    regfile #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1b;
        logic [63:0] e2b;
        logic [63:0] e1n;
        logic [63:0] e2n;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mdl [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          txn_id   = 0;

    function automatic void check(input string name, input int id, input logic [4:0] idx,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d idx=%0d got=%h expected=%h", name, id, idx, act, exp);
        end
    endfunction

    // Reference read: X31 is zero; with write-through, a live non-reset write to the
    // same index is seen immediately; otherwise the read returns the last stored value.
    function automatic logic [63:0] ref_read(input logic [4:0] idx, input bit byp);
        if (idx == 5'd31) return 64'd0;
        if (byp && RegWrite && !reset && WriteRegister == idx) return WriteData;
        return mdl[idx];
    endfunction

    task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        if (chk) begin
            e.id  = txn_id;
            e.r1  = r1;
            e.r2  = r2;
            e.e1b = ref_read(r1, 1'b1);
            e.e2b = ref_read(r2, 1'b1);
            e.e1n = ref_read(r1, 1'b0);
            e.e2n = ref_read(r2, 1'b0);
            sb_q.push_back(e);
            $display("txn %0d rst=%0b we=%0b wr=%0d wd=%h r1=%0d r2=%0d", txn_id, rst, we, wr, wd, r1, r2);
            txn_id++;
        end
        // The model takes effect at the coming edge.
        if (rst) begin
            for (int k = 0; k < 32; k++) mdl[k] = 64'd0;
        end else if (we && wr != 5'd31) begin
            mdl[wr] = wd;
        end
    endtask

    task automatic scan_all();
        for (int k = 0; k < 32; k++) cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'(k), 5'(k), 1'b1);
    endtask

    // Monitor: each cycle with a queued prediction, compare both ports of both instances.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd1_bypass",   e.id, e.r1, rd1_b, e.e1b);
            check("rd2_bypass",   e.id, e.r2, rd2_b, e.e2b);
            check("rd1_nobypass", e.id, e.r1, rd1_n, e.e1n);
            check("rd2_nobypass", e.id, e.r2, rd2_n, e.e2n);
        end
    end

    initial begin
        logic [4:0]  wr, r1, r2;
        logic [63:0] wd;
        logic        we, rst;

        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        for (int k = 0; k < 32; k++) mdl[k] = 64'd0;

        // The first reset edge, with unchecked pre-reset X contents.
        cyc(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
        // Everything reads 0 after reset.
        scan_all();

        // Test 1: write i*3, read the previous index on port 1 and the current index on port 2.
        for (int i = 0; i <= 30; i++)
            cyc(1'b0, 1'b1, 5'(i), 64'(i * 3), 5'((i + 31) % 32), 5'(i), 1'b1);
        scan_all();

        // Test 2: a write to X31 is dropped and is never bypassed.
        cyc(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
        cyc(1'b0, 1'b0, 5'd0,  64'd0,                   5'd31, 5'd31, 1'b1);

        // Test 3: a write-through of X5 on port 1; the non-bypass instance keeps the old value.
        cyc(1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd4, 1'b1);
        cyc(1'b0, 1'b0, 5'd0, 64'd0,    5'd5, 5'd5, 1'b1);

        // Test 4: with RegWrite low, nothing changes.
        cyc(1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b1);
        scan_all();

        // Test 6: back-to-back writes to X10 while port 2 watches X10.
        cyc(1'b0, 1'b1, 5'd10, 64'd1, 5'd0,  5'd10, 1'b1);
        cyc(1'b0, 1'b1, 5'd10, 64'd2, 5'd10, 5'd10, 1'b1);
        cyc(1'b0, 1'b0, 5'd0,  64'd0, 5'd10, 5'd10, 1'b1);

        // Test 5: load nonzero values, then apply reset together with a write to X9.
        for (int i = 1; i <= 30; i++)
            cyc(1'b0, 1'b1, 5'(i), {$urandom, $urandom} | 64'd1, 5'(i), 5'(i - 1), 1'b1);
        cyc(1'b1, 1'b1, 5'd9, 64'h55, 5'd9, 5'd9, 1'b1);
        scan_all();
        // Writes resume right after reset; X0 and X30 behave as ordinary registers.
        cyc(1'b0, 1'b1, 5'd0,  64'hA0, 5'd0,  5'd30, 1'b1);
        cyc(1'b0, 1'b1, 5'd30, 64'hB0, 5'd0,  5'd30, 1'b1);
        cyc(1'b0, 1'b0, 5'd0,  64'd0,  5'd30, 5'd0,  1'b1);

        // Random traffic; the reads hit the write target often, and reset is occasional.
        for (int n = 0; n < 400; n++) begin
            wr  = 5'($urandom_range(0, 31));
            we  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            wd  = {$urandom, $urandom};
            r1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc(rst, we, wr, wd, r1, r2, 1'b1);
        end
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
